// File: rtl/joy_dir_filter.sv
// Per-player joystick conditioning: SOCD cleaning, direction restriction
// (passthrough / 4-way last / 4-way first / 2-way) and per-button autofire.
module joy_dir_filter #(
    parameter int PLAYERS = 2,
    parameter int BTNS    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ce,
    input  logic [2*PLAYERS-1:0]    mode,
    input  logic                    socd,
    input  logic [BTNS*PLAYERS-1:0] af_en,
    input  logic [3:0]              af_rate,
    input  logic [4*PLAYERS-1:0]    joy_in,
    input  logic [BTNS*PLAYERS-1:0] btn_in,
    output logic [4*PLAYERS-1:0]    joy_out,
    output logic [BTNS*PLAYERS-1:0] btn_out
);

    localparam logic [1:0] M_PASS  = 2'd0;
    localparam logic [1:0] M_LAST  = 2'd1;
    localparam logic [1:0] M_FIRST = 2'd2;
    localparam logic [1:0] M_HORIZ = 2'd3;

    logic [4*PLAYERS-1:0]    s1;
    logic [BTNS*PLAYERS-1:0] b1;
    logic [3:0]              rate_eff;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            b1 <= '0;
        end else begin
            s1 <= joy_in;
            b1 <= btn_in;
        end
    end

    assign rate_eff = (af_rate == 4'd0) ? 4'd1 : af_rate;

    // Priority up > down > left > right when several edges arrive together.
    function automatic logic [3:0] pick(input logic [3:0] v);
        logic [3:0] r;
        r = 4'b0000;
        priority case (1'b1)
            v[3]:    r = 4'b1000;
            v[2]:    r = 4'b0100;
            v[1]:    r = 4'b0010;
            v[0]:    r = 4'b0001;
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

    for (genvar p = 0; p < PLAYERS; p++) begin : g_player
        logic [1:0] m;
        logic [1:0] mode_q;
        logic [3:0] raw;
        logic [3:0] c;
        logic [3:0] cprev;
        logic [3:0] nw;
        logic [3:0] mask;
        logic [3:0] mn;
        logic [3:0] jo;

        assign m   = mode[2*p +: 2];
        assign raw = s1[4*p +: 4];
        assign nw  = c & ~cprev;

        always_comb begin
            c = raw;
            if (socd) begin
                if (raw[3] && raw[2]) c[3:2] = 2'b00;
                if (raw[1] && raw[0]) c[1:0] = 2'b00;
            end
            if (m == M_HORIZ) c = c & 4'b0011;
        end

        // Release is judged against the old mask so a held direction keeps it.
        always_comb begin
            mn = mask;
            if (m != mode_q || m == M_PASS) begin
                mn = 4'hF;
            end else if ((c & mask) == 4'h0) begin
                mn = 4'hF;
            end else if ((m == M_LAST || m == M_HORIZ) && nw != 4'h0) begin
                mn = pick(nw);
            end else if (m == M_FIRST && nw != 4'h0 && mask == 4'hF) begin
                mn = pick(nw);
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                cprev  <= 4'h0;
                mask   <= 4'hF;
                jo     <= 4'h0;
                mode_q <= m;
            end else begin
                cprev  <= c;
                mask   <= mn;
                jo     <= c & mn;
                mode_q <= m;
            end
        end

        assign joy_out[4*p +: 4] = jo;
    end

    for (genvar i = 0; i < BTNS*PLAYERS; i++) begin : g_btn
        logic       bprev;
        logic       phase;
        logic       phase_n;
        logic [3:0] cnt;
        logic [3:0] cnt_n;
        logic [4:0] inc;
        logic       o;
        logic       o_n;

        assign inc = {1'b0, cnt} + 5'd1;

        always_comb begin
            phase_n = phase;
            cnt_n   = cnt;
            if (!af_en[i] || !b1[i] || !bprev) begin
                phase_n = 1'b1;
                cnt_n   = 4'd0;
            end else if (ce) begin
                if (inc >= {1'b0, rate_eff}) begin
                    cnt_n   = 4'd0;
                    phase_n = ~phase;
                end else begin
                    cnt_n = inc[3:0];
                end
            end
            o_n = af_en[i] ? (b1[i] & phase_n) : b1[i];
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                bprev <= 1'b0;
                phase <= 1'b1;
                cnt   <= 4'd0;
                o     <= 1'b0;
            end else begin
                bprev <= b1[i];
                phase <= phase_n;
                cnt   <= cnt_n;
                o     <= o_n;
            end
        end

        assign btn_out[i] = o;
    end

endmodule

// File: tb/tb_joy_dir_filter.sv
// Directed bench for joy_dir_filter: direction modes, SOCD, autofire, reset.
module tb_joy_dir_filter;

    logic       clk = 1'b0;
    logic       reset;
    logic       ce;
    logic [3:0] mode;
    logic       socd;
    logic [7:0] af_en;
    logic [3:0] af_rate;
    logic [7:0] joy_in;
    logic [7:0] btn_in;
    logic [7:0] joy_out;
    logic [7:0] btn_out;

    int total = 0;
    int bad   = 0;

    joy_dir_filter #(.PLAYERS(2), .BTNS(4)) dut (
        .clk(clk), .reset(reset), .ce(ce), .mode(mode), .socd(socd),
        .af_en(af_en), .af_rate(af_rate), .joy_in(joy_in), .btn_in(btn_in),
        .joy_out(joy_out), .btn_out(btn_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (joy_out !== 8'h00 || btn_out !== 8'h00) begin
                bad++;
                $display("FAIL reset: joy=%h btn=%h want 00 00", joy_out, btn_out);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_last_pressed();
        mode = 4'b0001;
        joy_in = 8'hC0;
        step(); step();
        joy_in = 8'hC1;
        step();
        total++;
        if (joy_out[3:0] !== 4'b0000) begin
            bad++;
            $display("FAIL lp_latency: got %b want 0000", joy_out[3:0]);
        end
        step();
        total++;
        if (joy_out !== 8'hC1) begin
            bad++;
            $display("FAIL lp_right: got %h want c1", joy_out);
        end
        joy_in = 8'hC9;
        step(); step();
        total++;
        if (joy_out !== 8'hC8) begin
            bad++;
            $display("FAIL lp_up: got %h want c8", joy_out);
        end
        joy_in = 8'hC1;
        step(); step();
        total++;
        if (joy_out !== 8'hC1) begin
            bad++;
            $display("FAIL lp_release_up: got %h want c1", joy_out);
        end
    endtask

    task automatic test_simultaneous();
        joy_in = 8'h00;
        step(); step();
        joy_in = 8'h0A;
        step(); step();
        total++;
        if (joy_out[3:0] !== 4'b1000) begin
            bad++;
            $display("FAIL sim_upleft: got %b want 1000", joy_out[3:0]);
        end
        joy_in = 8'h02;
        step();
        total++;
        if (joy_out[3:0] !== 4'b1000) begin
            bad++;
            $display("FAIL sim_hold: got %b want 1000", joy_out[3:0]);
        end
        step();
        total++;
        if (joy_out[3:0] !== 4'b0010) begin
            bad++;
            $display("FAIL sim_left: got %b want 0010", joy_out[3:0]);
        end
    endtask

    task automatic test_first_held();
        mode = 4'b0010;
        joy_in = 8'h00;
        step(); step();
        joy_in = 8'h02;
        step(); step();
        total++;
        if (joy_out[3:0] !== 4'b0010) begin
            bad++;
            $display("FAIL fh_left: got %b want 0010", joy_out[3:0]);
        end
        joy_in = 8'h06;
        step(); step();
        total++;
        if (joy_out[3:0] !== 4'b0010) begin
            bad++;
            $display("FAIL fh_ignore_down: got %b want 0010", joy_out[3:0]);
        end
        joy_in = 8'h04;
        step(); step();
        total++;
        if (joy_out[3:0] !== 4'b0100) begin
            bad++;
            $display("FAIL fh_release: got %b want 0100", joy_out[3:0]);
        end
    endtask

    task automatic test_socd();
        mode = 4'b0000;
        socd = 1'b1;
        joy_in = 8'h03;
        step(); step();
        total++;
        if (joy_out[3:0] !== 4'b0000) begin
            bad++;
            $display("FAIL socd_lr: got %b want 0000", joy_out[3:0]);
        end
        joy_in = 8'h0B;
        step(); step();
        total++;
        if (joy_out[3:0] !== 4'b1000) begin
            bad++;
            $display("FAIL socd_up: got %b want 1000", joy_out[3:0]);
        end
        mode = 4'b0011;
        joy_in = 8'h09;
        step(); step();
        total++;
        if (joy_out[3:0] !== 4'b0001) begin
            bad++;
            $display("FAIL horiz: got %b want 0001", joy_out[3:0]);
        end
        mode = 4'b0000;
        socd = 1'b0;
        joy_in = 8'h03;
        step(); step(); step();
        total++;
        if (joy_out[3:0] !== 4'b0011) begin
            bad++;
            $display("FAIL socd_off: got %b want 0011", joy_out[3:0]);
        end
        socd = 1'b1;
        step();
        total++;
        if (joy_out[3:0] !== 4'b0000) begin
            bad++;
            $display("FAIL socd_one_clk: got %b want 0000", joy_out[3:0]);
        end
        socd = 1'b0;
        joy_in = 8'h00;
        step(); step();
    endtask

    task automatic test_autofire();
        logic e;
        af_en = 8'h01;
        af_rate = 4'd2;
        btn_in = 8'h00;
        step(); step(); step();
        for (int i = 0; i <= 40; i++) begin
            btn_in = (i <= 33) ? 8'h01 : 8'h00;
            ce = (i % 4 == 3);
            step();
            e = (i >= 1 && i <= 6) || (i >= 15 && i <= 22) ||
                (i >= 31 && i <= 34);
            total++;
            if (btn_out !== {7'b0, e}) begin
                bad++;
                $display("FAIL af_rate2 i=%0d: got %h want %h", i, btn_out, {7'b0, e});
            end
        end
        af_rate = 4'd0;
        for (int i = 0; i <= 17; i++) begin
            btn_in = (i <= 15) ? 8'h01 : 8'h00;
            ce = (i % 4 == 3);
            step();
            e = (i >= 1 && i <= 2) || (i >= 7 && i <= 10) ||
                (i >= 15 && i <= 16);
            total++;
            if (btn_out !== {7'b0, e}) begin
                bad++;
                $display("FAIL af_rate0 i=%0d: got %h want %h", i, btn_out, {7'b0, e});
            end
        end
        ce = 1'b0;
    endtask

    task automatic test_af_off();
        btn_in = 8'h02;
        step();
        total++;
        if (btn_out !== 8'h00) begin
            bad++;
            $display("FAIL af_off_latency: got %h want 00", btn_out);
        end
        step();
        total++;
        if (btn_out !== 8'h02) begin
            bad++;
            $display("FAIL af_off_press: got %h want 02", btn_out);
        end
        btn_in = 8'h00;
        step(); step();
        total++;
        if (btn_out !== 8'h00) begin
            bad++;
            $display("FAIL af_off_release: got %h want 00", btn_out);
        end
    endtask

    task automatic test_reset_held();
        mode = 4'b0001;
        joy_in = 8'h01;
        step(); step(); step();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (joy_out !== 8'h00 || btn_out !== 8'h00) begin
                bad++;
                $display("FAIL rst_held i=%0d: joy=%h btn=%h want 00 00", i, joy_out, btn_out);
            end
        end
        reset = 1'b0;
        step();
        total++;
        if (joy_out[3:0] !== 4'b0000) begin
            bad++;
            $display("FAIL rst_exit1: got %b want 0000", joy_out[3:0]);
        end
        step();
        total++;
        if (joy_out[3:0] !== 4'b0001) begin
            bad++;
            $display("FAIL rst_exit2: got %b want 0001", joy_out[3:0]);
        end
    endtask

    task automatic test_mode_change();
        mode = 4'b0010;
        step();
        total++;
        if (joy_out[3:0] !== 4'b0001) begin
            bad++;
            $display("FAIL mchg1: got %b want 0001", joy_out[3:0]);
        end
        step();
        total++;
        if (joy_out[3:0] !== 4'b0001) begin
            bad++;
            $display("FAIL mchg2: got %b want 0001", joy_out[3:0]);
        end
        joy_in = 8'h05;
        step(); step();
        total++;
        if (joy_out[3:0] !== 4'b0100) begin
            bad++;
            $display("FAIL mchg_open: got %b want 0100", joy_out[3:0]);
        end
    endtask

    initial begin
        reset = 1'b1;
        ce = 1'b0;
        mode = 4'b0000;
        socd = 1'b0;
        af_en = 8'h00;
        af_rate = 4'd0;
        joy_in = 8'h00;
        btn_in = 8'h00;
        test_reset();
        test_last_pressed();
        test_simultaneous();
        test_first_held();
        test_socd();
        test_autofire();
        af_en = 8'h00;
        test_af_off();
        test_reset_held();
        test_mode_change();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/joy_dir_filter.md
# joy_dir_filter

Multi-player joystick conditioning block between `hps_io` joystick buses and core input mapping. Per player it applies optional SOCD cleaning and a selectable direction-restriction mode: passthrough, 4-way last-pressed, 4-way first-held, or 2-way horizontal. Per fire button it also applies optional autofire. It replaces per-player single-purpose direction filters with one parametrised instance.

## Interface
Parameters:
- `PLAYERS`, default 2: number of players.
- `BTNS`, default 4: fire buttons per player with autofire support.

Ports:
- `clk`  in  1: system clock (clk_sys).
- `reset`  in  1: synchronous, active-high.
- `ce`  in  1: autofire timebase tick, typically one per frame. Single-cycle pulse.
- `mode`  in  2*PLAYERS: player p is `mode[2p+1:2p]`. 0 = passthrough, 1 = 4-way last-pressed, 2 = 4-way first-held, 3 = 2-way horizontal.
- `socd`  in  1: 1 = opposing directions pressed together both read as released.
- `af_en`  in  BTNS*PLAYERS: per-button autofire enable. Index is `p*BTNS+b`.
- `af_rate`  in  4: autofire half-period in `ce` ticks. 0 is treated as 1.
- `joy_in`  in  4*PLAYERS: player p is `joy_in[4p+3:4p]`, ordered {up, down, left, right}.
- `btn_in`  in  BTNS*PLAYERS: raw buttons, active-high.
- `joy_out`  out  4*PLAYERS: filtered directions, registered.
- `btn_out`  out  BTNS*PLAYERS: filtered buttons, registered.

## Operation
- Input stage: `s1 <= joy_in`, `b1 <= btn_in`. All logic below operates on `s1`/`b1`.
- SOCD cleaning, combinational on `s1`. When `socd` = 1, up&down both set gives both 0, and left&right both set gives both 0. The result is `c`.
- Mode 3 pre-mask: `c &= 4'b0011`.
- Edge detection: `new = c & ~cprev`, then `cprev <= c`. Each player has its own `cprev`.
- Each player has a one-hot-or-open direction mask `mask`, reset value 4'hF. The next-mask `mn` is evaluated in this priority order:
  1. Mode changed (mode differs from registered `mode_q`) or mode = 0 → `mn = 4'hF`.
  2. `(c & mask) == 0` → `mn = 4'hF`. This is the release path, and it is checked against the old mask.
  3. Mode 1 or 3, `new != 0` → `mn` = one-hot of the highest set bit of `new`. Priority is up > down > left > right.
  4. Mode 2, `new != 0`, `mask == 4'hF` → `mn` = one-hot of the highest set bit of `new`. If `mask != 4'hF`, new edges are ignored.
  5. Otherwise `mn = mask`.
- Register updates: `mask <= mn`, `joy_out <= c & mn`, `mode_q <= mode`.
- Autofire: each button has a 4-bit counter `cnt` and a `phase` bit.
  - `af_en` = 0: `btn_out <= b1`, `cnt <= 0`, `phase <= 1`.
  - `af_en` = 1 and `b1` rising: `phase <= 1`, `cnt <= 0`, `btn_out <= 1`. The first shot is immediate.
  - `af_en` = 1, held, `ce` = 1: `cnt+1 >= max(af_rate,1)` → `cnt <= 0`, `phase <= ~phase`. Otherwise `cnt <= cnt+1`.
  - `btn_out <= b1 & phase_next`.
  - Release: `btn_out` goes to 0 on the next register update. `phase <= 1`, `cnt <= 0`.
  - `af_rate` changes mid-hold: the new value applies at the next compare. `cnt` at or above the new rate toggles at the next `ce`.
- Reset values: `joy_out` = 0, `btn_out` = 0, `s1`/`b1`/`cprev` = 0, `mask` = 4'hF, `phase` = 1, `cnt` = 0, `mode_q` = `mode` sampled at reset.
- Inputs held across reset behave as fresh presses once reset deasserts, because `cprev` = 0.

## Timing
- Latency from `joy_in`/`btn_in` to outputs is 2 clocks: the `s1` stage, then the output register. There is no combinational input-to-output path.
- Mode and `socd` changes take effect in the output 1 clock after the change.
- Autofire toggle period is `max(af_rate,1)` `ce` ticks per half-cycle. A `ce` in the press cycle does not advance `cnt`.
- Players are fully independent. A mask update for one player has no cycle coupling to another player.

## Test plan
- Reset, then mode = 1, press right at cycle 10 and up at cycle 20, release up at 30 → `joy_out` = 4'b0001 from cycle 12, 4'b1000 from 22, 4'b0001 from 32.
- Mode = 1, press up+left in the same cycle → `joy_out` = 4'b1000 only. Release up with left still held → 4'b0010 two cycles later.
- Mode = 2, hold left, then press down → output stays 4'b0010. Release left → mask opens and output is 4'b0100.
- `socd` = 1, mode = 0, joy = 4'b0011 → 4'b0000. Then joy = 4'b1011 → 4'b1000. Mode = 3 with joy = 4'b1001 → 4'b0001.
- `af_en` = 1, `af_rate` = 2, `ce` every 4 clocks, hold btn 40 clocks → `btn_out` starts at 1, then toggles every second `ce`, and returns to 0 two clocks after release. `af_rate` = 0 → toggles every `ce`.
- Hold right in mode 1, assert `reset` for 3 cycles, then deassert → outputs are 0 during reset and `joy_out` = 4'b0001 again 2 cycles after deassert. Change mode 1→2 while held → mask reopens for one update and the output is unchanged.
